// File: rtl/div_pkg.sv
// Shared types and constants for the divider result BCD converter.
package div_pkg;

   localparam int DIV_W      = 16;
   localparam int BCD_DIGITS = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration: add-3 per digit, then shift.
module bcd_dabble_step #(
   parameter int W      = 16,
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] bcd_i,
   input  logic [W-1:0]        bin_i,
   output logic [4*DIGITS-1:0] bcd_o,
   output logic [W-1:0]        bin_o
);

   logic [4*DIGITS-1:0] adj;

   always_comb begin
      adj = bcd_i;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_i[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
      {bcd_o, bin_o} = {adj[4*DIGITS-2:0], bin_i, 1'b0};
   end

endmodule

// File: rtl/div_result_bcd.sv
// Converts a divider quotient/remainder pair to packed BCD, both in parallel.
module div_result_bcd
   import div_pkg::*;
#(
   parameter int W      = DIV_W,
   parameter int DIGITS = BCD_DIGITS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [W-1:0]        quotient,
   input  logic [W-1:0]        remainder,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] q_bcd,
   output logic [4*DIGITS-1:0] r_bcd
);

   localparam int CW = $clog2(W + 1);
   localparam int BW = 4 * DIGITS;

   bcd_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  qbin_q, qbin_d, rbin_q, rbin_d;
   logic [BW-1:0] qacc_q, qacc_d, racc_q, racc_d;
   logic [BW-1:0] qout_q, qout_d, rout_q, rout_d;
   logic          ov_q, ov_d;

   logic [BW-1:0] qacc_n, racc_n;
   logic [W-1:0]  qbin_n, rbin_n;
   logic          accept;

   bcd_dabble_step #(.W(W), .DIGITS(DIGITS)) u_q_step (
      .bcd_i (qacc_q),
      .bin_i (qbin_q),
      .bcd_o (qacc_n),
      .bin_o (qbin_n)
   );

   bcd_dabble_step #(.W(W), .DIGITS(DIGITS)) u_r_step (
      .bcd_i (racc_q),
      .bin_i (rbin_q),
      .bcd_o (racc_n),
      .bin_o (rbin_n)
   );

   assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = ov_q;
   assign q_bcd     = qout_q;
   assign r_bcd     = rout_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qbin_d  = qbin_q;
      rbin_d  = rbin_q;
      qacc_d  = qacc_q;
      racc_d  = racc_q;
      qout_d  = qout_q;
      rout_d  = rout_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: ;
         SHIFT: begin
            qbin_d = qbin_n;
            rbin_d = rbin_n;
            qacc_d = qacc_n;
            racc_d = racc_n;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               qout_d  = qacc_n;
               rout_d  = racc_n;
               ov_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // a new accept overrides the IDLE return from DONE
      if (accept) begin
         qbin_d  = quotient;
         rbin_d  = remainder;
         qacc_d  = '0;
         racc_d  = '0;
         cnt_d   = '0;
         state_d = SHIFT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         qbin_q  <= '0;
         rbin_q  <= '0;
         qacc_q  <= '0;
         racc_q  <= '0;
         qout_q  <= '0;
         rout_q  <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qbin_q  <= qbin_d;
         rbin_q  <= rbin_d;
         qacc_q  <= qacc_d;
         racc_q  <= racc_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
         ov_q    <= ov_d;
      end
   end

endmodule
